multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control unit for the multi-cycle RV32I core.
- A Moore main FSM sequences the shared datapath (PC, instruction/data memory, register file, the single 32-bit ALU) across fetch, decode, execute, memory and writeback cycles.
- Also generates the 3-bit alu_control word for every ALU use, including PC+4 and branch-target adds.
- Sits between the instruction register and the datapath; it is the only driver of the ALU's control input.

Parameters:
- RESET_STATE, FETCH, state entered on reset (kept as a parameter for bring-up only; always FETCH in product).

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load enable
- result_src  output  2  00 = ALUOut, 01 = data reg, 10 = ALU result
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- alu_src_b  output  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4
- imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
- reg_write  output  1  register file write enable
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor
- state_dbg  output  4  current state encoding (debug/verification)

Behaviour:
- One clock; reset is synchronous and active-high. Reset sampled on the clk rising edge forces state to FETCH, aborting any instruction mid-flight.
- Outputs are a combinational decode of the registered state (plus op/funct for alu_control, imm_src and the branch enable). During and right after reset, outputs equal the FETCH values:
  - adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_control=000, result_src=10, pc_write=1.
  - All other enables 0.
- Enables not listed for a state are 0. Mux selects not listed are don't-care and are driven to 0.
- States and transitions:
  - FETCH: fetch, as above. Next state DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_control=000 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other op -> FETCH (treated as NOP; PC already advanced).
  - MEMADR: alu_src_a=10, alu_src_b=01, add. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_control=decoded. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_control=decoded. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write = zero when funct3=000 (beq), = !zero when funct3=001 (bne), else 0. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB.
- CPI: load 5; store, R-type, I-type and jal 4; branch 3; unknown op 2.
- imm_src is decoded from op every cycle: 0100011 -> S, 1100011 -> B, 1101111 -> J, else I.
- ALU decode, by funct3 (only in EXECUTER/EXECUTEI):
  - 000: sub only when op=0110011 and funct7b5=1, else add
  - 001: sll; 010: slt; 100: xor; 101: srl; 110: or; 111: and
  - 011: add (unsupported sltu)
- Unused state encodings decode to FETCH next cycle, with all enables 0 in that cycle.

Decomposition:
- Shared package: state encodings, opcode constants, ALU control codes, imm_src/result_src/src select codes. The ALU and the datapath use the same package.
- One sub-module: alu_decoder (purely combinational: state class, op, funct3, funct7b5 -> alu_control).

Test Plan:
- Reset asserted for 2 cycles, then op=0110011: state_dbg=FETCH on first post-reset cycle with pc_write=1, ir_write=1, alu_control=000. Then DECODE, EXECUTER, ALUWB, FETCH (4 cycles).
- op=0110011, funct3=000, funct7b5=1: alu_control=001 in EXECUTER. Same with funct7b5=1 on op=0010011: alu_control=000 (addi). funct3=101: 110; funct3=100: 111.
- lw (op=0000011): FETCH, DECODE, MEMADR, MEMREAD (adr_src=1), MEMWB (result_src=01, reg_write=1). sw (op=0100011): MEMWRITE with mem_write=1 for exactly one cycle, imm_src=01.
- beq zero=1: pc_write=1 in BRANCH. beq zero=0: pc_write=0. bne zero=0: pc_write=1. alu_control=001 in all cases, imm_src=10.
- jal: JAL state pc_write=1, alu_src_a=01, alu_src_b=10. Then ALUWB with reg_write=1; imm_src=11.
- Reset mid-MEMWRITE, and op=1111111: reset gives FETCH next cycle with mem_write=0. Illegal op goes DECODE -> FETCH, no reg_write/mem_write.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, opcodes, ALU control
// and datapath mux select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSll = 3'b100,
    AluSlt = 3'b101,
    AluSrl = 3'b110,
    AluXor = 3'b111
  } alu_ctrl_e;

  // Which class of ALU use the current state needs.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    unique case (op)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decode: fixed add/sub for address and compare uses, funct-driven
// operation for R- and I-type execute.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl = AluAdd;
    unique case (alu_op)
      AluOpSub: ctrl = AluSub;
      AluOpFunct: begin
        unique case (funct3)
          // funct7b5 on an I-type is immediate bits, so only R-type may subtract.
          3'b000:  ctrl = (op == OpRtype && funct7b5) ? AluSub : AluAdd;
          3'b001:  ctrl = AluSll;
          3'b010:  ctrl = AluSlt;
          3'b011:  ctrl = AluAdd;
          3'b100:  ctrl = AluXor;
          3'b101:  ctrl = AluSrl;
          3'b110:  ctrl = AluOr;
          default: ctrl = AluAnd;
        endcase
      end
      default: ctrl = AluAdd;
    endcase
  end

  assign alu_control = ctrl;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core; outputs are a Moore decode of the
// registered state, with op/funct only steering ALU, immediate and branch decisions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter state_e RESET_STATE = StFetch
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic [3:0] state_dbg
);

  state_e  state_q, state_d;
  alu_op_e alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    reg_write  = 1'b0;
    alu_op     = AluOpAdd;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpSub;
        if (funct3 == 3'b000)      pc_write = zero;
        else if (funct3 == 3'b001) pc_write = ~zero;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  assign imm_src   = imm_src_of(op);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state and outputs are
// queued as each instruction is driven and compared on the falling edge.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .alu_control (alu_control),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src,
  //  reg_write, alu_control}
  function automatic logic [15:0] exp_outs(input state_e st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7,
                                           input logic z);
    logic pw = 0, adr = 0, mw = 0, ir = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm;
    logic [2:0] ac = 3'b000, dec;
    case (f3)
      3'b000:  dec = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b001:  dec = 3'b100;
      3'b010:  dec = 3'b101;
      3'b011:  dec = 3'b000;
      3'b100:  dec = 3'b111;
      3'b101:  dec = 3'b110;
      3'b110:  dec = 3'b011;
      default: dec = 3'b010;
    endcase
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (st)
      StFetch:    begin pw = 1; ir = 1; rs = 2'b10; sb = 2'b10; end
      StDecode:   begin sa = 2'b01; sb = 2'b01; end
      StMemAdr:   begin sa = 2'b10; sb = 2'b01; end
      StMemRead:  adr = 1;
      StMemWb:    begin rs = 2'b01; rw = 1; end
      StMemWrite: begin adr = 1; mw = 1; end
      StExecuteR: begin sa = 2'b10; ac = dec; end
      StExecuteI: begin sa = 2'b10; sb = 2'b01; ac = dec; end
      StAluWb:    rw = 1;
      StBranch: begin
        sa = 2'b10; ac = 3'b001;
        pw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
      end
      StJal:      begin sa = 2'b01; sb = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, adr, mw, ir, rs, sa, sb, imm, rw, ac};
  endfunction

  task automatic push(input state_e st, input string tag);
    sb_q.push_back({st, exp_outs(st, op, funct3, funct7b5, zero)});
    tag_q.push_back(tag);
  endtask

  // Drives one instruction from its FETCH cycle; abort_at >= 0 asserts reset in that
  // cycle of the sequence and then holds reset for one more cycle in FETCH.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int abort_at);
    state_e seq[$];
    seq.push_back(StFetch);
    seq.push_back(StDecode);
    case (o)
      7'b0000011: begin seq.push_back(StMemAdr); seq.push_back(StMemRead);
                        seq.push_back(StMemWb); end
      7'b0100011: begin seq.push_back(StMemAdr); seq.push_back(StMemWrite); end
      7'b0110011: begin seq.push_back(StExecuteR); seq.push_back(StAluWb); end
      7'b0010011: begin seq.push_back(StExecuteI); seq.push_back(StAluWb); end
      7'b1100011: seq.push_back(StBranch);
      7'b1101111: begin seq.push_back(StJal); seq.push_back(StAluWb); end
      default: ;
    endcase
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int i = 0; i < seq.size(); i++) begin
      push(seq[i], $sformatf("%s_c%0d", name, i));
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        push(StFetch, {name, "_rst"});
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_state"}, {28'd0, state_dbg}, {28'd0, e.st});
      check({t, "_outs"}, {16'd0, pc_write, adr_src, mem_write, ir_write, result_src,
                           alu_src_a, alu_src_b, imm_src, reg_write, alu_control},
            {16'd0, e.outs});
    end
  end

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    push(StFetch, "in_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("add",    7'b0110011, 3'b000, 1'b0, 1'b0, -1);
    run_instr("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, -1);
    run_instr("addi",   7'b0010011, 3'b000, 1'b1, 1'b0, -1);
    run_instr("srl",    7'b0110011, 3'b101, 1'b0, 1'b0, -1);
    run_instr("xor",    7'b0110011, 3'b100, 1'b0, 1'b0, -1);
    run_instr("slti",   7'b0010011, 3'b010, 1'b0, 1'b0, -1);
    run_instr("or",     7'b0110011, 3'b110, 1'b0, 1'b0, -1);
    run_instr("andi",   7'b0010011, 3'b111, 1'b0, 1'b0, -1);
    run_instr("sll",    7'b0110011, 3'b001, 1'b0, 1'b0, -1);
    run_instr("sltu",   7'b0110011, 3'b011, 1'b0, 1'b0, -1);
    run_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    run_instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, -1);
    run_instr("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, -1);
    run_instr("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, -1);
    run_instr("bne_t",  7'b1100011, 3'b001, 1'b0, 1'b0, -1);
    run_instr("bne_nt", 7'b1100011, 3'b001, 1'b0, 1'b1, -1);
    run_instr("blt",    7'b1100011, 3'b100, 1'b0, 1'b1, -1);
    run_instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, -1);
    run_instr("sw_abt", 7'b0100011, 3'b010, 1'b0, 1'b0, 3);
    run_instr("ill",    7'b1111111, 3'b000, 1'b0, 1'b0, -1);
    run_instr("add2",   7'b0110011, 3'b000, 1'b0, 1'b0, -1);

    @(posedge clk); #1;
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
